// File: rtl/memory_pkg.sv
// Shared sizing for the riscy32 data memory: word width tracks XLEN, depth in words.
package memory_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_DEPTH = 4096;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/memory.sv
// Word-per-address data memory: synchronous write, combinational read, async clear.
// Latency: write commits at the rising edge, read is 0 cycles; no backpressure, never stalls.
module memory
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = XLEN,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [IDX_W-1:0]      idx;

  // Upper address bits alias onto the same word.
  assign idx = address[IDX_W-1:0];

  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (write_enable) begin
      mem[idx] <= data_in;
    end
  end

  assign data_out = mem[idx];

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed tables, hand sequences and a randomized reference model.
module tb_memory;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] pre;
    logic [31:0] post;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  logic [31:0] model [DEPTH];
  int vectors = 0;
  int miscompares = 0;
  vec_t vecs [10];

  function automatic int widx(input logic [31:0] a);
    return int'(a % DEPTH);
  endfunction

  task automatic model_reset();
    foreach (model[i]) model[i] = '0;
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    vectors++;
    if (data_out !== exp) begin
      miscompares++;
      $display("FAIL %s: data_out=%h expected=%h (addr=%h)", name, data_out, exp, address);
    end
  endtask

  // One clock of traffic: check just after driving (old contents) and just after the edge.
  task automatic step(input string name, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] pre, input logic [31:0] post);
    @(negedge clk);
    write_enable = we;
    address      = a;
    data_in      = d;
    #1 check({name, "/pre"}, pre);
    @(posedge clk);
    #1 check({name, "/post"}, post);
    if (we) model[widx(a)] = d;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    step(name, 1'b0, a, 32'h0, exp, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, pre, post;
    logic we;

    vecs[0] = '{1'b1, 32'h8542_391A, 32'hDEAD_BEEF, 32'h0000_091A, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h8542_391A, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_091A, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         32'h0};
    vecs[4] = '{1'b0, 32'h0000_0001, 32'h0,         32'h1,         32'h1};
    vecs[5] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'hFFF,       32'hFFF};
    vecs[6] = '{1'b1, 32'h0000_0FFF, 32'hA5A5_A5A5, 32'hFFF,       32'hA5A5_A5A5};
    vecs[7] = '{1'b1, 32'h0000_1FFF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h1234_5678};
    vecs[8] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'h1234_5678, 32'h1234_5678};
    vecs[9] = '{1'b0, 32'h0000_091B, 32'h0,         32'h91B,       32'h91B};

    // Reset held: output zero and writes ignored.
    model_reset();
    #2 check("rst_hold", 32'h0);
    @(negedge clk);
    write_enable = 1'b1;
    address      = 32'h5;
    data_in      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 check("rst_write_ignored", 32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b0;

    rd("rst_rd0", 32'h0, 32'h0);
    rd("rst_rd1", 32'h1, 32'h0);
    rd("rst_rd4095", 32'hFFF, 32'h0);
    rd("rst_wrap", 32'h1000, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      write_enable = 1'b1;
      address      = 32'(i);
      data_in      = 32'(i);
      model[i]     = 32'(i);
    end
    @(negedge clk);
    write_enable = 1'b0;
    rd("fill_rd1", 32'h1, 32'h1);
    rd("fill_rd4095", 32'hFFF, 32'hFFF);
    rd("fill_wrap", 32'h1000, 32'h0);

    for (int i = 0; i < 10; i++)
      step($sformatf("table%0d", i), vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].pre, vecs[i].post);

    for (int i = 2; i <= 9; i++)
      step($sformatf("burst_wr%0d", i), 1'b1, 32'h10 | 32'(i), 32'(2 * i), 32'h10 | 32'(i), 32'(2 * i));
    rd("burst_nb_lo", 32'h11, 32'h11);
    for (int i = 2; i <= 9; i++)
      rd($sformatf("burst_rd%0d", i), 32'h10 | 32'(i), 32'(2 * i));
    rd("burst_nb_hi", 32'h1A, 32'h1A);

    // Random traffic on a small index window with random alias bits.
    for (int n = 0; n < 400; n++) begin
      we   = 1'($urandom_range(0, 1));
      a    = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
      d    = $urandom();
      pre  = model[widx(a)];
      post = we ? d : pre;
      step($sformatf("rand%0d", n), we, a, d, pre, post);
    end

    // Asynchronous reset between edges with a write pending.
    @(negedge clk);
    write_enable = 1'b1;
    address      = 32'h12;
    data_in      = 32'h0000_0055;
    #1 check("arst_before", model[widx(32'h12)]);
    #2 rst_n = 1'b0;
    #1 check("arst_immediate", 32'h0);
    @(posedge clk);
    #1 check("arst_write_dropped", 32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b0;
    model_reset();
    #1 check("arst_cleared", 32'h0);
    step("arst_no_recovery", 1'b1, 32'h33, 32'hCAFE, 32'h0, 32'hCAFE);
    rd("arst_other", 32'h12, 32'h0);
    rd("arst_wrap", 32'h1000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
